// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file: the clear-sequencer
// state encoding and the default data/address widths used by the top module
// and its sub-module.
// -----------------------------------------------------------------------------
package rf_pkg;

   // Clear sequencer states: IDLE waits for a CLEAR request, SWEEP zeroes
   // one register per clock until the whole array has been visited.
   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } rf_state_t;

   // Default geometry: an 8-entry array of 8-bit registers.
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

endpackage : rf_pkg

// File: rtl/rf_clear_seq.sv
// -----------------------------------------------------------------------------
// rf_clear_seq
// Hardware clear sequencer. On a CLEAR request in IDLE it walks an index from
// 0 to DEPTH-1, one entry per clock, telling the register array which entry
// to zero. CLEAR is ignored while a sweep is already running.
//
// Ports:
//   CLK       in   clock, all state changes on the rising edge
//   RESET     in   asynchronous active-low reset
//   CLEAR     in   start-clear request, sampled at the clock edge
//   BUSY      out  sweep in progress
//   CLR_EN    out  zero the entry at CLR_ADDR at the next edge
//   CLR_ADDR  out  entry currently being swept
// -----------------------------------------------------------------------------
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
)
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CLEAR,
   output logic              BUSY,
   output logic              CLR_EN,
   output logic [ADDR_W-1:0] CLR_ADDR
);

   rf_state_t         state;
   rf_state_t         stateNext;
   logic [ADDR_W-1:0] sweepIndex;
   logic [ADDR_W-1:0] sweepIndexNext;

   // State and index register. Reset aborts any sweep in progress and puts
   // the sequencer straight back into IDLE with the index at zero.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         sweepIndex <= '0;
      end else begin
         state      <= stateNext;
         sweepIndex <= sweepIndexNext;
      end
   end

   // Next-state logic. The sweep ends on the edge that clears the last entry
   // (index all ones); the increment then wraps the index back to zero, so
   // no separate reload is needed on the way out of SWEEP.
   always_comb begin
      stateNext      = state;
      sweepIndexNext = sweepIndex;
      case (state)
         IDLE: begin
            if (CLEAR) begin
               stateNext      = SWEEP;
               sweepIndexNext = '0;
            end
         end
         SWEEP: begin
            sweepIndexNext = sweepIndex + 1'b1;
            if (&sweepIndex) begin
               stateNext = IDLE;
            end
         end
      endcase
   end

   assign BUSY     = (state == SWEEP);
   assign CLR_EN   = (state == SWEEP);
   assign CLR_ADDR = sweepIndex;

endmodule : rf_clear_seq

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
// Parametrised register file for the CPU datapath: two combinational read
// ports, one synchronous write port, optional same-cycle write forwarding,
// optional hard-wired zero register 0, and a hardware clear sweep that zeroes
// the array one entry per cycle.
//
// Parameters:
//   DATA_W   register width (signed two's complement data)
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   BYPASS   1 = forward an accepted write to matching read ports
//   R0_ZERO  1 = register 0 reads as 0 and ignores writes
//
// Ports:
//   CLK          in   clock
//   RESET        in   asynchronous active-low reset
//   WRITE        in   write enable
//   INADDRESS    in   write address
//   IN           in   write data
//   OUT1ADDRESS  in   read port 1 address
//   OUT2ADDRESS  in   read port 2 address
//   OUT1         out  read port 1 data
//   OUT2         out  read port 2 data
//   CLEAR        in   start-clear request
//   BUSY         out  clear sweep in progress
//   WR_REJECT    out  WRITE asserted while the write cannot be accepted
// -----------------------------------------------------------------------------
module reg_file_param
   import rf_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int BYPASS  = 1,
   parameter int R0_ZERO = 0
)
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   input  logic              CLEAR,
   output logic              BUSY,
   output logic              WR_REJECT
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic                         busy;
   logic                         clrEn;
   logic [ADDR_W-1:0]            clrAddr;
   logic                         r0Target;
   logic                         writeAccept;
   logic                         writeCommit;

   rf_clear_seq #(
      .ADDR_W   (ADDR_W)
   ) clearSeq (
      .CLK      (CLK),
      .RESET    (RESET),
      .CLEAR    (CLEAR),
      .BUSY     (busy),
      .CLR_EN   (clrEn),
      .CLR_ADDR (clrAddr)
   );

   // A write is accepted whenever no sweep is running. A write aimed at the
   // hard-wired zero register still counts as accepted (no reject), but it
   // never reaches the array and is never forwarded.
   assign r0Target    = (R0_ZERO != 0) && (INADDRESS == '0);
   assign writeAccept = WRITE & ~busy;
   assign writeCommit = writeAccept & ~r0Target;

   // Array update. The sweep and the write port never collide because writes
   // are refused while busy; the sweep is still given priority so the array
   // has exactly one writer per cycle by construction.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         regs <= '0;
      end else if (clrEn) begin
         regs[clrAddr] <= '0;
      end else if (writeCommit) begin
         regs[INADDRESS] <= IN;
      end
   end

   // Read port 1. Forwarding only happens for a committed write, which
   // already excludes the sweep and writes to a hard-wired zero register.
   // The zero-register override is applied last so it always wins.
   always_comb begin
      OUT1 = regs[OUT1ADDRESS];
      if ((BYPASS != 0) && writeCommit && (OUT1ADDRESS == INADDRESS)) begin
         OUT1 = IN;
      end
      if ((R0_ZERO != 0) && (OUT1ADDRESS == '0)) begin
         OUT1 = '0;
      end
   end

   // Read port 2, identical behaviour to port 1 on its own address.
   always_comb begin
      OUT2 = regs[OUT2ADDRESS];
      if ((BYPASS != 0) && writeCommit && (OUT2ADDRESS == INADDRESS)) begin
         OUT2 = IN;
      end
      if ((R0_ZERO != 0) && (OUT2ADDRESS == '0)) begin
         OUT2 = '0;
      end
   end

   assign BUSY      = busy;
   assign WR_REJECT = WRITE & busy;

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
// Directed bench for reg_file_param. Three instances cover the configurations
// of interest: A = 8x8 with forwarding, B = 8x8 without forwarding and with a
// hard-wired zero register, C = 16x16 with forwarding. Stimulus tasks push the
// expected value of each observed output into a scoreboard queue; a separate
// monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

   localparam int K_OUT1 = 0;
   localparam int K_OUT2 = 1;
   localparam int K_BUSY = 2;
   localparam int K_REJ  = 3;

   typedef struct {
      int          dut;
      int          kind;
      logic [15:0] expVal;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rstN;
   logic [2:0]  wrEn;
   logic [2:0]  clrReq;
   logic [3:0]  inAddr;
   logic [15:0] inData;
   logic [3:0]  rd1;
   logic [3:0]  rd2;
   logic [7:0]  aOut1, aOut2, bOut1, bOut2;
   logic [15:0] cOut1, cOut2;
   logic [2:0]  busy;
   logic [2:0]  rej;

   exp_t sbQ[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .R0_ZERO(0)) dutA (
      .CLK(clk), .RESET(rstN[0]), .WRITE(wrEn[0]), .INADDRESS(inAddr[2:0]),
      .IN(inData[7:0]), .OUT1ADDRESS(rd1[2:0]), .OUT2ADDRESS(rd2[2:0]),
      .OUT1(aOut1), .OUT2(aOut2), .CLEAR(clrReq[0]), .BUSY(busy[0]),
      .WR_REJECT(rej[0])
   );

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .R0_ZERO(1)) dutB (
      .CLK(clk), .RESET(rstN[1]), .WRITE(wrEn[1]), .INADDRESS(inAddr[2:0]),
      .IN(inData[7:0]), .OUT1ADDRESS(rd1[2:0]), .OUT2ADDRESS(rd2[2:0]),
      .OUT1(bOut1), .OUT2(bOut2), .CLEAR(clrReq[1]), .BUSY(busy[1]),
      .WR_REJECT(rej[1])
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .R0_ZERO(0)) dutC (
      .CLK(clk), .RESET(rstN[2]), .WRITE(wrEn[2]), .INADDRESS(inAddr),
      .IN(inData), .OUT1ADDRESS(rd1), .OUT2ADDRESS(rd2),
      .OUT1(cOut1), .OUT2(cOut2), .CLEAR(clrReq[2]), .BUSY(busy[2]),
      .WR_REJECT(rej[2])
   );

   // Fetch the observed value of one output of one instance, zero-extended.
   function automatic logic [15:0] actual(input int dut, input int kind);
      logic [15:0] v;
      v = '0;
      case (dut)
         0: case (kind)
               K_OUT1: v = {8'h00, aOut1};
               K_OUT2: v = {8'h00, aOut2};
               K_BUSY: v = {15'h0, busy[0]};
               default: v = {15'h0, rej[0]};
            endcase
         1: case (kind)
               K_OUT1: v = {8'h00, bOut1};
               K_OUT2: v = {8'h00, bOut2};
               K_BUSY: v = {15'h0, busy[1]};
               default: v = {15'h0, rej[1]};
            endcase
         default: case (kind)
               K_OUT1: v = cOut1;
               K_OUT2: v = cOut2;
               K_BUSY: v = {15'h0, busy[2]};
               default: v = {15'h0, rej[2]};
            endcase
      endcase
      return v;
   endfunction

   // Monitor: everything queued during the current cycle is compared on the
   // falling edge, well away from the rising edge where state changes.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] act;
      while (sbQ.size() > 0) begin
         e   = sbQ.pop_front();
         act = actual(e.dut, e.kind);
         checks++;
         if (act === e.expVal) begin
            passed++;
         end else begin
            $display("[TB] FAIL %s (dut %0d): got %h, expected %h",
                     e.name, e.dut, act, e.expVal);
         end
      end
   end

   // Drive one cycle of stimulus to the selected instance, just after the
   // rising edge. Write and clear of the other instances are held low.
   task automatic applyStimulus(input int dut, input int wr, input int wa,
                                input int wd, input int a1, input int a2,
                                input int clr);
      @(posedge clk);
      #1;
      wrEn        = '0;
      clrReq      = '0;
      wrEn[dut]   = (wr != 0);
      clrReq[dut] = (clr != 0);
      inAddr      = 4'(wa);
      inData      = 16'(wd);
      rd1         = 4'(a1);
      rd2         = 4'(a2);
   endtask

   // Change the reset level of one instance mid-cycle (asynchronous).
   task automatic setReset(input int dut, input logic val, input int a1,
                           input int a2);
      @(posedge clk);
      #1;
      wrEn      = '0;
      clrReq    = '0;
      rstN[dut] = val;
      rd1       = 4'(a1);
      rd2       = 4'(a2);
   endtask

   // Queue one expected output value for the monitor to compare this cycle.
   task automatic checkOutput(input int dut, input int kind, input int expVal,
                              input string name);
      exp_t e;
      e.dut    = dut;
      e.kind   = kind;
      e.expVal = 16'(expVal);
      e.name   = name;
      sbQ.push_back(e);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN   = '0;
      wrEn   = 3'b001;
      clrReq = '0;
      inAddr = '0;
      inData = '0;
      rd1    = 4'd1;
      rd2    = 4'd6;
      checkOutput(0, K_OUT1, 0, "initRstOut1");
      checkOutput(0, K_OUT2, 0, "initRstOut2");
      checkOutput(0, K_BUSY, 0, "initRstBusy");
      checkOutput(0, K_REJ,  0, "initRstRej");
      @(posedge clk);
      #1;
      wrEn = '0;
      rstN = '1;

      // ---- Instance A: 8x8, forwarding on ----
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, i, 'h5A, i, i, 0);
         checkOutput(0, K_OUT1, 'h5A, "preloadBypass");
      end
      applyStimulus(0, 0, 0, 0, 2, 7, 0);
      checkOutput(0, K_OUT1, 'h5A, "preloadR2");
      checkOutput(0, K_OUT2, 'h5A, "preloadR7");
      setReset(0, 1'b0, 2, 7);
      checkOutput(0, K_OUT1, 0, "asyncRstOut1");
      checkOutput(0, K_OUT2, 0, "asyncRstOut2");
      checkOutput(0, K_BUSY, 0, "asyncRstBusy");
      setReset(0, 1'b1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0, 2 * k, 2 * k + 1, 0);
         checkOutput(0, K_OUT1, 0, "postRstEven");
         checkOutput(0, K_OUT2, 0, "postRstOdd");
      end
      applyStimulus(0, 1, 3, 'hF9, 3, 0, 0);
      checkOutput(0, K_OUT1, 'hF9, "bypassSameCycle");
      checkOutput(0, K_OUT2, 0, "bypassOtherPort");
      checkOutput(0, K_REJ, 0, "idleWriteNoReject");
      applyStimulus(0, 0, 0, 0, 3, 3, 0);
      checkOutput(0, K_OUT1, 'hF9, "writeNextCycle1");
      checkOutput(0, K_OUT2, 'hF9, "writeNextCycle2");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, i, i + 1, i, 0, 0);
         checkOutput(0, K_OUT1, i + 1, "seqPreload");
      end
      applyStimulus(0, 0, 0, 0, 0, 7, 1);
      checkOutput(0, K_BUSY, 0, "clearReqCycleBusy");
      checkOutput(0, K_OUT1, 1, "clearReqCycleR0");
      checkOutput(0, K_OUT2, 8, "clearReqCycleR7");
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(0, (j == 4) ? 1 : 0, 7, 99, (j == 4) ? 7 : j - 1,
                       (j >= 2) ? j - 2 : 7, 0);
         checkOutput(0, K_BUSY, 1, "sweepBusy");
         checkOutput(0, K_OUT1, (j == 4) ? 8 : j, "sweepNotYetCleared");
         checkOutput(0, K_OUT2, (j >= 2) ? 0 : 8, "sweepAlreadyCleared");
         checkOutput(0, K_REJ, (j == 4) ? 1 : 0, "sweepWriteReject");
      end
      applyStimulus(0, 1, 2, 'h33, 7, 2, 0);
      checkOutput(0, K_BUSY, 0, "sweepDoneBusy");
      checkOutput(0, K_OUT1, 0, "rejectedWriteR7");
      checkOutput(0, K_OUT2, 'h33, "resumeWriteBypass");
      checkOutput(0, K_REJ, 0, "resumeWriteNoReject");
      applyStimulus(0, 0, 0, 0, 2, 6, 0);
      checkOutput(0, K_OUT1, 'h33, "resumeWriteStored");
      checkOutput(0, K_OUT2, 0, "sweepClearedR6");

      // ---- Instance B: 8x8, no forwarding, R0 hard-wired to zero ----
      applyStimulus(1, 1, 5, 9, 0, 0, 0);
      applyStimulus(1, 1, 5, 20, 0, 5, 0);
      checkOutput(1, K_OUT2, 9, "noBypassOldValue");
      applyStimulus(1, 0, 0, 0, 0, 5, 0);
      checkOutput(1, K_OUT2, 20, "noBypassNewValue");
      applyStimulus(1, 1, 0, 77, 0, 5, 0);
      checkOutput(1, K_OUT1, 0, "r0WriteSameCycle");
      checkOutput(1, K_OUT2, 20, "r0WriteOtherReg");
      checkOutput(1, K_REJ, 0, "r0WriteNoReject");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput(1, K_OUT1, 0, "r0AfterWrite1");
      checkOutput(1, K_OUT2, 0, "r0AfterWrite2");
      applyStimulus(1, 1, 3, 'hF9, 3, 0, 0);
      checkOutput(1, K_OUT1, 0, "noBypassR3Old");
      applyStimulus(1, 0, 0, 0, 3, 0, 0);
      checkOutput(1, K_OUT1, 'hF9, "noBypassR3New");

      // ---- Instance C: 16x16, reset during sweep ----
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2, 1, i, 'h1000 + i, i, 0, 0);
         checkOutput(2, K_OUT1, 'h1000 + i, "wideBypass");
      end
      applyStimulus(2, 0, 0, 0, 15, 10, 1);
      checkOutput(2, K_BUSY, 0, "wideClearReqBusy");
      for (int j = 1; j <= 4; j++) begin
         applyStimulus(2, 0, 0, 0, 15, 10, 0);
         checkOutput(2, K_BUSY, 1, "wideSweepBusy");
         checkOutput(2, K_OUT1, 'h100F, "wideSweepR15");
      end
      setReset(2, 1'b0, 15, 10);
      checkOutput(2, K_BUSY, 0, "abortBusy");
      checkOutput(2, K_OUT1, 0, "abortR15");
      checkOutput(2, K_OUT2, 0, "abortR10");
      setReset(2, 1'b1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2, 0, 0, 0, 2 * k, 2 * k + 1, 0);
         checkOutput(2, K_OUT1, 0, "abortAllZeroEven");
         checkOutput(2, K_OUT2, 0, "abortAllZeroOdd");
         checkOutput(2, K_BUSY, 0, "abortIdle");
      end
      applyStimulus(2, 1, 15, 'hBEEF, 15, 0, 0);
      checkOutput(2, K_OUT1, 'hBEEF, "wideWriteR15");
      applyStimulus(2, 0, 0, 0, 15, 0, 1);
      checkOutput(2, K_BUSY, 0, "fullClearReqBusy");
      for (int j = 1; j <= 16; j++) begin
         applyStimulus(2, 0, 0, 0, 15, 0, 0);
         checkOutput(2, K_BUSY, 1, "fullSweepBusy");
         checkOutput(2, K_OUT1, 'hBEEF, "fullSweepR15Pending");
      end
      applyStimulus(2, 0, 0, 0, 15, 0, 0);
      checkOutput(2, K_BUSY, 0, "fullSweepDone");
      checkOutput(2, K_OUT1, 0, "fullSweepR15Cleared");

      @(negedge clk);
      #1;
      if (sbQ.size() != 0) begin
         $display("[TB] FAIL scoreboard: %0d expectations never compared",
                  sbQ.size());
      end
      if (checks < 12) begin
         $display("[TB] FAIL coverage: only %0d checks executed", checks);
      end
      if (passed != checks) begin
         $display("[TB] FAIL summary: %0d of %0d checks failed",
                  checks - passed, checks);
      end else begin
         $display("[TB] PASS all checks");
      end
      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_reg_file_param

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the 8×8 processor register file, with configurable data width, register count and read-port forwarding. Adds a hardware clear sequencer that zeroes the array one entry per cycle, and an optional hard-wired zero register. It sits between the instruction decoder and the ALU/writeback path of the CPU datapath: two combinational read ports and one synchronous write port.

## Interface
- DATA_W, 8: register width in bits; data is treated as signed two's complement.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1: 1 = an accepted same-cycle write is forwarded to matching read ports; 0 = no forwarding.
- R0_ZERO, 0: 1 = register 0 always reads 0 and writes to it are discarded.

- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WRITE  in  1  write enable, active high.
- INADDRESS  in  ADDR_W  write address.
- IN  in  DATA_W  write data.
- OUT1ADDRESS  in  ADDR_W  read port 1 address.
- OUT2ADDRESS  in  ADDR_W  read port 2 address.
- OUT1  out  DATA_W  read port 1 data.
- OUT2  out  DATA_W  read port 2 data.
- CLEAR  in  1  start-clear request, sampled at the clock edge.
- BUSY  out  1  clear sweep in progress.
- WR_REJECT  out  1  WRITE is high but the write is not accepted this cycle.

## Operation
- Reset (RESET=0, asynchronous): all registers 0, FSM in IDLE, sweep index 0, BUSY=0. OUT1 and OUT2 read 0 and WR_REJECT=0 (it is combinational, so it also requires BUSY=0).
- Reset release: synchronous deassert by an upstream synchroniser; the block needs no extra handling.
- Write: if WRITE=1 and BUSY=0, register[INADDRESS] <= IN at the rising edge. This is an "accepted write".
- Write to address 0 when R0_ZERO=1: counts as accepted but the array is unchanged, and no bypass occurs.
- Read: OUTn = register[OUTnADDRESS], purely combinational. No `#` delays in RTL.
- Bypass (BYPASS=1): if an accepted write is pending and OUTnADDRESS == INADDRESS, then OUTn = IN in the same cycle. Both ports may bypass at once.
- R0_ZERO=1: OUTn = 0 whenever OUTnADDRESS = 0, regardless of bypass.
- Clear FSM, states IDLE and SWEEP:
  - IDLE → SWEEP when CLEAR=1; the index is loaded with 0.
  - In SWEEP: register[index] <= 0 on each edge, then index += 1.
  - SWEEP → IDLE after the edge that clears entry DEPTH-1; the index wraps to 0.
- BUSY = (state == SWEEP).
- CLEAR while in SWEEP is ignored; the sweep does not restart.
- Writes during SWEEP are dropped. WR_REJECT = WRITE & BUSY. Writes are never queued.
- Reads during SWEEP return current contents: already-swept entries read 0, entries not yet swept read their old values. No bypass occurs while BUSY.
- Reset during SWEEP aborts the sweep immediately; the full reset state applies.

## Timing
- Read latency 0 cycles, combinational from address or array.
- Write visible on OUTn the cycle after the accepting edge. With BYPASS=1 it is visible in the same cycle.
- Clear: CLEAR sampled at edge T. BUSY rises after T and falls after edge T+DEPTH, so BUSY is high for exactly DEPTH cycles.
- Write acceptance resumes at edge T+DEPTH+1.
- A WRITE and CLEAR asserted together in IDLE: the write is accepted at edge T, then the sweep starts. The written register is cleared during the sweep.

## Structure
- Package rf_pkg: state enum rf_state_t {IDLE, SWEEP}, plus the defaults DATA_W_DEF = 8 and ADDR_W_DEF = 3.
- Sub-module rf_clear_seq holds the FSM and sweep index.
  - Ports: CLK, RESET, CLEAR, BUSY, CLR_EN, CLR_ADDR.
  - The top module muxes the array write between the sequencer and the write port.
- The array is a single reg vector [DEPTH-1:0][DATA_W-1:0] with one write per cycle.

## Test plan
- Reset asserted with all registers preloaded to 8'h5A → all 8 registers = 0 and OUT1/OUT2 = 0 immediately (asynchronous); BUSY=0.
- Write 8'sd-7 to R3, then read OUT1ADDRESS=3 → OUT1 = 8'hF9 on the next cycle. With BYPASS=1, OUT1 = 8'hF9 in the same cycle as the write.
- BYPASS=0, write 8'd20 to R5 while OUT2ADDRESS=5 and R5 held 8'd9 → OUT2 = 9 in that cycle, 20 after the edge.
- R0_ZERO=1, write 8'd77 to R0 → OUT1 (addr 0) = 0 in the same cycle and afterwards; WR_REJECT=0.
- Preload R0..R7 = 1..8, pulse CLEAR → BUSY high for exactly 8 cycles, and after k edges R0..R(k-1) read 0. A WRITE of 8'd99 to R7 mid-sweep gives WR_REJECT=1 and R7 ends at 0.
- DEPTH=16, DATA_W=16, reset pulsed low in the 5th sweep cycle → BUSY=0 immediately and all registers = 0. A CLEAR after release runs a full 16-cycle sweep.
